ntt_bfly_seq: RTL and testbench

NTT_BFLY_SEQ -- requirements
Module: ntt_bfly_seq

---
 rtl/ntt_pkg.sv | 30 +++
 rtl/ntt_bfly_seq_mod_mul_q.sv | 59 +++++
 rtl/ntt_bfly_seq.sv | 178 +++++++++++++++++
 tb/tb_ntt_bfly_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg -- shared constants and types for the NTT butterfly sequencer.
//   NTT_Q / NTT_DATA_WIDTH : Kyber-style modulus and coefficient width
//   BARRETT_SHIFT / _MUL   : Barrett reduction constants, floor(2^24 / 3329) = 5039
//   state_t                : sequencer state encoding
//   stage_t                : one pipeline slot (valid + butterfly addresses)
package ntt_pkg;

  localparam int NTT_DATA_WIDTH = 12;
  localparam int NTT_Q          = 3329;
  localparam int BARRETT_SHIFT  = 24;
  localparam int BARRETT_MUL    = 5039;

  localparam int ADDR_W  = 8;   // coefficient RAM address width (256 entries)
  localparam int ZADDR_W = 6;   // zeta ROM address width (64 entries)
  localparam int CNT_W   = 7;   // butterfly index 0..127

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
  } stage_t;

endpackage

// File: rtl/ntt_bfly_seq_mod_mul_q.sv
// mod_mul_q -- r = x*y mod Q, two register stages.
//   Stage 1 registers the full 2*DATA_WIDTH product.
//   Stage 2 registers the Barrett remainder, which lies in [0, 2Q).
//   A single conditional subtraction of Q after stage 2 gives the exact
//   result, valid combinationally two cycles after x/y are presented.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   x, y     : operands in [0, Q-1]
//   r        : x*y mod Q, two cycles after x/y
module mod_mul_q
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = NTT_DATA_WIDTH,
  parameter int Q          = NTT_Q
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  output logic [DATA_WIDTH-1:0] r
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int MW = $clog2(BARRETT_MUL + 1);
  localparam int EW = PW + MW;

  localparam logic [EW-1:0]         MUL_E = EW'(BARRETT_MUL);
  localparam logic [PW-1:0]         Q_P   = PW'(Q);
  localparam logic [DATA_WIDTH:0]   Q_R   = (DATA_WIDTH + 1)'(Q);

  logic [PW-1:0]         prod_q;
  logic [PW-1:0]         qhat;
  logic [DATA_WIDTH:0]   rem_d;
  logic [DATA_WIDTH:0]   rem_q;

  // qhat under-estimates floor(p/Q) by at most one because p < 2^24,
  // so the remainder is below 2Q and fits in DATA_WIDTH+1 bits.
  always_comb begin
    qhat  = PW'((EW'(prod_q) * MUL_E) >> BARRETT_SHIFT);
    rem_d = (DATA_WIDTH + 1)'(prod_q - qhat * Q_P);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  // NOTE: the datapath registers are reset as well so all outputs are a
  // clean zero while rst is held; they are few, so the cost is negligible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      rem_q  <= '0;
    end else begin
      prod_q <= PW'(x) * PW'(y);
      rem_q  <= rem_d;
    end
  end

  assign r = (rem_q >= Q_R) ? DATA_WIDTH'(rem_q - Q_R) : DATA_WIDTH'(rem_q);

endmodule

// File: rtl/ntt_bfly_seq.sv
// ntt_bfly_seq -- sequences one NTT layer pass of 128 in-place butterflies
// over a 256-entry coefficient RAM with a synchronous zeta ROM.
//   Butterfly i: g = i>>1, j = i&1, a at 4g+j, b at 4g+j+2, zeta at g.
//   Forward (Cooley-Tukey): t = zeta*b; a' = a+t; b' = a-t   (all mod Q)
// Optional feature macro NTT_BFLY_INVERSE_EN adds inv_mode, which selects
// the Gentleman-Sande butterfly: a' = a+b; b' = zeta*(b-a)   (all mod Q).
// Pipeline (issue at cycle N): N+1 read data, N+2 product, N+3 remainder
// and add/sub, N+4 registered write.
// Ports:
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   start                 : one-cycle pulse, accepted only in IDLE
//   inv_mode              : (NTT_BFLY_INVERSE_EN only) sampled at start
//   busy, done            : pass in progress / one-cycle completion pulse
//   zeta_addr, zeta_data  : zeta ROM port, 1-cycle read latency
//   rd_en, rd_addr_a/b    : coefficient RAM read port
//   rd_data_a/b           : read data, valid one cycle after rd_en
//   wr_en, wr_addr_a/b    : coefficient RAM write port
//   wr_data_a/b           : butterfly results
module ntt_bfly_seq
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = NTT_DATA_WIDTH,
  parameter int Q          = NTT_Q
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef NTT_BFLY_INVERSE_EN
  input  logic                  inv_mode,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ZADDR_W-1:0]    zeta_addr,
  input  logic [DATA_WIDTH-1:0] zeta_data,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr_a,
  output logic [ADDR_W-1:0]     rd_addr_b,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr_a,
  output logic [ADDR_W-1:0]     wr_addr_b,
  output logic [DATA_WIDTH-1:0] wr_data_a,
  output logic [DATA_WIDTH-1:0] wr_data_b
);

  localparam logic [DATA_WIDTH:0] Q_R      = (DATA_WIDTH + 1)'(Q);
  localparam logic [CNT_W-1:0]    LAST_IDX = '1;

  function automatic logic [DATA_WIDTH-1:0] add_mod(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= Q_R) ? DATA_WIDTH'(s - Q_R) : DATA_WIDTH'(s);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sub_mod(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return (a >= b) ? (a - b) : DATA_WIDTH'({1'b0, a} + Q_R - {1'b0, b});
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  stage_t                issue, s1_q, s2_q, s3_q;
  logic [DATA_WIDTH-1:0] a_path, mul_y, t;
  logic [DATA_WIDTH-1:0] a2_q, a3_q;
  logic [DATA_WIDTH-1:0] res_a, res_b;
  logic                  last_retire;

  // The final write is retiring when nothing remains behind it in the pipe.
  assign last_retire = wr_en && !s1_q.valid && !s2_q.valid && !s3_q.valid;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)             state_d = ST_RUN;
      ST_RUN:   if (cnt_q == LAST_IDX) state_d = ST_DRAIN;
      ST_DRAIN: if (last_retire)       state_d = ST_DONE;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == ST_RUN) ? cnt_q + 1'b1 : '0;
    end
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

  // Addresses are forced to zero outside RUN so the read port is quiet.
  // a and b differ only in bit 1, and each address is read once and
  // written four cycles later, so in-place updates never race a read.
  always_comb begin
    issue = '0;
    if (state_q == ST_RUN) begin
      issue.valid  = 1'b1;
      issue.addr_a = {cnt_q[CNT_W-1:1], 1'b0, cnt_q[0]};
      issue.addr_b = {cnt_q[CNT_W-1:1], 1'b1, cnt_q[0]};
    end
  end

  assign rd_en     = issue.valid;
  assign rd_addr_a = issue.addr_a;
  assign rd_addr_b = issue.addr_b;
  assign zeta_addr = (state_q == ST_RUN) ? cnt_q[CNT_W-1:1] : '0;

`ifdef NTT_BFLY_INVERSE_EN
  logic inv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                inv_q <= 1'b0;
    else if (state_q == ST_IDLE && start)   inv_q <= inv_mode;
  end

  always_comb begin
    mul_y  = inv_q ? sub_mod(rd_data_b, rd_data_a) : rd_data_b;
    a_path = inv_q ? add_mod(rd_data_a, rd_data_b) : rd_data_a;
    res_a  = inv_q ? a3_q : add_mod(a3_q, t);
    res_b  = inv_q ? t    : sub_mod(a3_q, t);
  end
`else
  always_comb begin
    mul_y  = rd_data_b;
    a_path = rd_data_a;
    res_a  = add_mod(a3_q, t);
    res_b  = sub_mod(a3_q, t);
  end
`endif

  mod_mul_q #(
    .DATA_WIDTH (DATA_WIDTH),
    .Q          (Q)
  ) u_mod_mul (
    .clk (clk),
    .rst (rst),
    .x   (zeta_data),
    .y   (mul_y),
    .r   (t)
  );

  // The a-operand (or a+b in inverse mode) travels alongside the
  // multiplier's two stages so both meet at N+3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      a2_q      <= '0;
      a3_q      <= '0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      wr_data_a <= '0;
      wr_data_b <= '0;
    end else begin
      s1_q      <= issue;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      a2_q      <= a_path;
      a3_q      <= a2_q;
      wr_en     <= s3_q.valid;
      wr_addr_a <= s3_q.addr_a;
      wr_addr_b <= s3_q.addr_b;
      wr_data_a <= res_a;
      wr_data_b <= res_b;
    end
  end

endmodule

// File: tb/tb_ntt_bfly_seq.sv
// tb_ntt_bfly_seq -- self-checking bench for ntt_bfly_seq with behavioural
// coefficient RAM and zeta ROM. Expected writes are queued when each pass
// starts and compared as wr_en retires them.
module tb_ntt_bfly_seq;

  localparam int Q = 3329;

  typedef struct {
    int cyc;
    int aa;
    int ab;
    int da;
    int db;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
`ifdef NTT_BFLY_INVERSE_EN
  logic        inv_mode;
`endif
  logic        busy, done;
  logic [5:0]  zeta_addr;
  logic [11:0] zeta_data;
  logic        rd_en;
  logic [7:0]  rd_addr_a, rd_addr_b;
  logic [11:0] rd_data_a, rd_data_b;
  logic        wr_en;
  logic [7:0]  wr_addr_a, wr_addr_b;
  logic [11:0] wr_data_a, wr_data_b;

  logic [11:0] ram      [256];
  logic [11:0] init_ram [256];
  logic [11:0] rom      [64];
  logic        load;

  int   cyc = 0;
  int   s_cyc = 0;
  int   rd_idx, rd_cnt, wr_cnt, done_cnt;
  bit   track;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  ntt_bfly_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef NTT_BFLY_INVERSE_EN
    .inv_mode  (inv_mode),
`endif
    .busy      (busy),
    .done      (done),
    .zeta_addr (zeta_addr),
    .zeta_data (zeta_data),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .wr_data_a (wr_data_a),
    .wr_data_b (wr_data_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memories: synchronous reads, writes on wr_en, bulk load from init_ram.
  initial begin
    rd_data_a = '0;
    rd_data_b = '0;
    zeta_data = '0;
  end

  always @(posedge clk) begin
    zeta_data <= rom[zeta_addr];
    if (rd_en) begin
      rd_data_a <= ram[rd_addr_a];
      rd_data_b <= ram[rd_addr_b];
    end
    if (load) begin
      for (int k = 0; k < 256; k++) ram[k] <= init_ram[k];
    end else if (wr_en) begin
      ram[wr_addr_a] <= wr_data_a;
      ram[wr_addr_b] <= wr_data_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int i, input bit inv);
    exp_t e;
    int g, a, b, z, t;
    g    = i >> 1;
    e.aa = 4 * g + (i & 1);
    e.ab = e.aa + 2;
    a    = int'(init_ram[e.aa]);
    b    = int'(init_ram[e.ab]);
    z    = int'(rom[g]);
    if (!inv) begin
      t    = (z * b) % Q;
      e.da = (a + t) % Q;
      e.db = (a - t + Q) % Q;
    end else begin
      e.da = (a + b) % Q;
      e.db = (z * ((b - a + Q) % Q)) % Q;
    end
    e.cyc = s_cyc + 5 + i;
    return e;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (track) begin
      check("busy_window", busy, (cyc >= s_cyc + 1 && cyc <= s_cyc + 132));
      check("rd_en_window", rd_en, (cyc >= s_cyc + 1 && cyc <= s_cyc + 128));
    end
    if (rd_en) begin
      check("rd_addr_a", rd_addr_a, 4 * (rd_idx >> 1) + (rd_idx & 1));
      check("rd_addr_b", rd_addr_b, 4 * (rd_idx >> 1) + (rd_idx & 1) + 2);
      check("zeta_addr", zeta_addr, rd_idx >> 1);
      check("rd_cycle", cyc, s_cyc + 1 + rd_idx);
      rd_idx++;
      rd_cnt++;
    end
    if (done) begin
      done_cnt++;
      check("done_cycle", cyc, s_cyc + 133);
    end
    if (wr_en) begin
      wr_cnt++;
      check("sb_nonempty_on_write", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_addr_a", wr_addr_a, e.aa);
        check("wr_addr_b", wr_addr_b, e.ab);
        check("wr_data_a", wr_data_a, e.da);
        check("wr_data_b", wr_data_b, e.db);
      end
    end
  end

  task automatic fill_mem();
    for (int k = 0; k < 256; k++) init_ram[k] = 12'($urandom_range(Q - 1, 0));
    for (int k = 0; k < 64; k++)  rom[k]      = 12'($urandom_range(Q - 1, 0));
    // Directed vectors and range extremes.
    rom[0]      = 12'd2285; init_ram[0] = 12'd1;    init_ram[2] = 12'd1;
    rom[1]      = 12'd3328; init_ram[4] = 12'd3328; init_ram[6] = 12'd3328;
    rom[2]      = 12'd0;    init_ram[8] = 12'd3328; init_ram[10] = 12'd0;
    rom[63]     = 12'd3328; init_ram[253] = 12'd0;  init_ram[255] = 12'd3328;
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic start_pass(input bit inv);
    s_cyc    = cyc;
    rd_idx   = 0;
    rd_cnt   = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    sb.delete();
    for (int i = 0; i < 128; i++) sb.push_back(model(i, inv));
`ifdef NTT_BFLY_INVERSE_EN
    inv_mode = inv;
`endif
    start = 1'b1;
  endtask

  // Runs the pass to S+145; optional extra start pulses at S+10 and S+133.
  task automatic run_pass(input bit extra);
    while (cyc < s_cyc + 145) begin
      @(posedge clk); #1;
      start = extra && (cyc == s_cyc + 10 || cyc == s_cyc + 133);
`ifdef NTT_BFLY_INVERSE_EN
      inv_mode = 1'b0;  // must have no effect once the pass has started
`endif
    end
    check("pass_writes", wr_cnt, 128);
    check("pass_reads", rd_cnt, 128);
    check("pass_done_pulses", done_cnt, 1);
    check("pass_sb_empty", sb.size(), 0);
    check("pass_idle_busy", busy, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    load  = 1'b0;
    track = 1'b0;
`ifdef NTT_BFLY_INVERSE_EN
    inv_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr_a", rd_addr_a, 0);
    check("rst_rd_addr_b", rd_addr_b, 0);
    check("rst_zeta_addr", zeta_addr, 0);
    check("rst_wr_addr_a", wr_addr_a, 0);
    check("rst_wr_addr_b", wr_addr_b, 0);
    check("rst_wr_data_a", wr_data_a, 0);
    check("rst_wr_data_b", wr_data_b, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Pass 1: full forward pass with ignored start pulses at S+10 and S+133.
    fill_mem();
    track = 1'b1;
    start_pass(1'b0);
    run_pass(1'b1);
    check("vec_2285_1_1_a", ram[0], 2286);
    check("vec_2285_1_1_b", ram[2], 1045);
    check("vec_3328_a", ram[4], 0);
    check("vec_3328_b", ram[6], 3327);

    // Pass 2: reset at S+60 aborts the pass.
    fill_mem();
    track = 1'b0;
    start_pass(1'b0);
    while (cyc < s_cyc + 60) begin
      @(posedge clk); #1 start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_rd_en", rd_en, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    while (cyc < s_cyc + 145) @(posedge clk);
    #1;
    check("abort_writes", wr_cnt, 55);
    check("abort_reads", rd_cnt, 59);
    check("abort_done_pulses", done_cnt, 0);
    check("abort_partial_written", ram[0], model(0, 1'b0).da);
    check("abort_unwritten", ram[111], init_ram[111]);
    sb.delete();

    // Pass 3: a fresh start after the abort completes normally.
    fill_mem();
    track = 1'b1;
    start_pass(1'b0);
    run_pass(1'b0);

`ifdef NTT_BFLY_INVERSE_EN
    // Pass 4: Gentleman-Sande butterfly.
    fill_mem();
    init_ram[2] = 12'd2;
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    start_pass(1'b1);
    run_pass(1'b0);
    check("inv_vec_a", ram[0], 3);
    check("inv_vec_b", ram[2], 2285);
`endif

    track = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
